// File: rtl/map_table.sv
// Speculative rename map table.
// Holds the current arch->physical tag mapping and a ready bit per
// architectural register. Dispatch reads source mappings, renames rd and
// reports the displaced tag. The CDB marks tags ready. Rollback reloads
// every entry from the architectural (retire-side) map table.
//
// Interface contract: dispatch has no valid/ready handshake. dp_valid_i
// alone qualifies a slot, and it is never back-pressured. Upstream
// guarantees that a free tag is present on dp_tag_new_i whenever a slot
// is valid. CDB broadcasts are fire-and-forget, qualified by cdb_valid_i.
module map_table #(
  parameter int C_DP_NUM        = 2,
  parameter int C_CDB_NUM       = 2,
  parameter int C_MT_ENTRY      = 32,
  parameter int C_TAG_IDX_WIDTH = 6
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                rollback_i,
  input  logic [C_MT_ENTRY*C_TAG_IDX_WIDTH-1:0] amt_tag_i,
  input  logic [C_DP_NUM-1:0]                 dp_valid_i,
  input  logic [C_DP_NUM*5-1:0]               dp_rs1_i,
  input  logic [C_DP_NUM*5-1:0]               dp_rs2_i,
  input  logic [C_DP_NUM*5-1:0]               dp_rd_i,
  input  logic [C_DP_NUM-1:0]                 dp_wr_en_i,
  input  logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0] dp_tag_new_i,
  input  logic [C_CDB_NUM-1:0]                cdb_valid_i,
  input  logic [C_CDB_NUM*C_TAG_IDX_WIDTH-1:0] cdb_tag_i,
  output logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0] rs1_tag_o,
  output logic [C_DP_NUM-1:0]                 rs1_ready_o,
  output logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0] rs2_tag_o,
  output logic [C_DP_NUM-1:0]                 rs2_ready_o,
  output logic [C_DP_NUM*C_TAG_IDX_WIDTH-1:0] tag_old_o
);

  localparam int T = C_TAG_IDX_WIDTH;

  logic [T-1:0]          tag_q [C_MT_ENTRY];
  logic [T-1:0]          tag_d [C_MT_ENTRY];
  logic [C_MT_ENTRY-1:0] rdy_q;
  logic [C_MT_ENTRY-1:0] rdy_d;
  logic [C_MT_ENTRY-1:0] cdb_match;
  logic [C_DP_NUM-1:0]   wr_act;

  // Per-entry flag: some valid CDB lane carries the tag currently mapped there.
  always_comb begin
    cdb_match = '0;
    for (int i = 0; i < C_MT_ENTRY; i++) begin
      for (int c = 0; c < C_CDB_NUM; c++) begin
        if (cdb_valid_i[c] && (cdb_tag_i[c*T +: T] == tag_q[i])) begin
          cdb_match[i] = 1'b1;
        end
      end
    end
  end

  // A slot renames only if valid, writing, and not targeting x0.
  always_comb begin
    wr_act = '0;
    for (int k = 0; k < C_DP_NUM; k++) begin
      wr_act[k] = dp_valid_i[k] & dp_wr_en_i[k] & (dp_rd_i[k*5 +: 5] != 5'd0);
    end
  end

  // Lookups: older-slot forwarding first, then table plus CDB bypass.
  // Operand index s: 0 = rs1, 1 = rs2, 2 = rd (for tag_old).
  always_comb begin
    logic [4:0]   src;
    logic [T-1:0] t;
    logic         r;
    rs1_tag_o   = '0;
    rs1_ready_o = '0;
    rs2_tag_o   = '0;
    rs2_ready_o = '0;
    tag_old_o   = '0;
    src         = '0;
    t           = '0;
    r           = 1'b0;
    for (int k = 0; k < C_DP_NUM; k++) begin
      for (int s = 0; s < 3; s++) begin
        if (s == 0) begin
          src = dp_rs1_i[k*5 +: 5];
        end else if (s == 1) begin
          src = dp_rs2_i[k*5 +: 5];
        end else begin
          src = dp_rd_i[k*5 +: 5];
        end
        t = tag_q[src];
        r = rdy_q[src] | cdb_match[src];
        // Ascending scan: the youngest older slot overrides earlier hits.
        for (int j = 0; j < C_DP_NUM; j++) begin
          if ((j < k) && wr_act[j] && (dp_rd_i[j*5 +: 5] == src)) begin
            t = dp_tag_new_i[j*T +: T];
            r = 1'b0;
          end
        end
        // x0 is hardwired: tag 0, always ready (tag_old is unused for x0).
        if ((s != 2) && (src == 5'd0)) begin
          t = '0;
          r = 1'b1;
        end
        if (s == 0) begin
          rs1_tag_o[k*T +: T] = t;
          rs1_ready_o[k]      = r;
        end else if (s == 1) begin
          rs2_tag_o[k*T +: T] = t;
          rs2_ready_o[k]      = r;
        end else begin
          tag_old_o[k*T +: T] = t;
        end
      end
    end
  end

  // Next state: CDB sets ready, then renames override in slot order so
  // the youngest slot wins and a rename beats a CDB hit on the old tag.
  always_comb begin
    for (int i = 0; i < C_MT_ENTRY; i++) begin
      tag_d[i] = tag_q[i];
    end
    rdy_d = rdy_q | cdb_match;
    for (int k = 0; k < C_DP_NUM; k++) begin
      if (wr_act[k]) begin
        tag_d[dp_rd_i[k*5 +: 5]] = dp_tag_new_i[k*T +: T];
        rdy_d[dp_rd_i[k*5 +: 5]] = 1'b0;
      end
    end
  end

  // State register: reset to identity map, rollback reloads from AMT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < C_MT_ENTRY; i++) begin
        tag_q[i] <= T'(i);
      end
      rdy_q <= '1;
    end else if (rollback_i) begin
      for (int i = 0; i < C_MT_ENTRY; i++) begin
        tag_q[i] <= amt_tag_i[i*T +: T];
      end
      rdy_q <= '1;
    end else begin
      for (int i = 0; i < C_MT_ENTRY; i++) begin
        tag_q[i] <= tag_d[i];
      end
      rdy_q <= rdy_d;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Testbench for map_table: table-driven dispatch/CDB vectors followed by
// hand-written rollback and mid-operation reset sequences.
module tb_map_table;

  localparam int DP  = 2;
  localparam int CDB = 2;
  localparam int NE  = 32;
  localparam int T   = 6;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              rollback;
  logic [NE*T-1:0]   amt_tag;
  logic [DP-1:0]     dp_valid;
  logic [DP*5-1:0]   dp_rs1;
  logic [DP*5-1:0]   dp_rs2;
  logic [DP*5-1:0]   dp_rd;
  logic [DP-1:0]     dp_wr_en;
  logic [DP*T-1:0]   dp_tag_new;
  logic [CDB-1:0]    cdb_valid;
  logic [CDB*T-1:0]  cdb_tag;
  logic [DP*T-1:0]   rs1_tag;
  logic [DP-1:0]     rs1_ready;
  logic [DP*T-1:0]   rs2_tag;
  logic [DP-1:0]     rs2_ready;
  logic [DP*T-1:0]   tag_old;

  map_table #(
    .C_DP_NUM(DP), .C_CDB_NUM(CDB), .C_MT_ENTRY(NE), .C_TAG_IDX_WIDTH(T)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rollback_i(rollback), .amt_tag_i(amt_tag),
    .dp_valid_i(dp_valid), .dp_rs1_i(dp_rs1), .dp_rs2_i(dp_rs2), .dp_rd_i(dp_rd),
    .dp_wr_en_i(dp_wr_en), .dp_tag_new_i(dp_tag_new),
    .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
    .rs1_tag_o(rs1_tag), .rs1_ready_o(rs1_ready),
    .rs2_tag_o(rs2_tag), .rs2_ready_o(rs2_ready), .tag_old_o(tag_old)
  );

  // Scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [T-1:0] act, input logic [T-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Vector record: inputs for both slots plus expected lookup results
  typedef struct {
    string      name;
    logic [1:0] valid, wr;
    logic [4:0] a1, a2, ad, b1, b2, bd;
    logic [5:0] an, bn;
    logic [1:0] cv;
    logic [5:0] c0, c1;
    logic [5:0] e_a1, e_a2, e_b1, e_b2;
    logic       r_a1, r_a2, r_b1, r_b2;
    logic [1:0] omask;
    logic [5:0] eo0, eo1;
  } vec_t;

  function automatic vec_t mk(
    input string name, input logic [1:0] valid, input logic [1:0] wr,
    input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad, input logic [5:0] an,
    input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd, input logic [5:0] bn,
    input logic [1:0] cv, input logic [5:0] c0, input logic [5:0] c1,
    input logic [5:0] e_a1, input logic r_a1, input logic [5:0] e_a2, input logic r_a2,
    input logic [5:0] e_b1, input logic r_b1, input logic [5:0] e_b2, input logic r_b2,
    input logic [1:0] omask, input logic [5:0] eo0, input logic [5:0] eo1);
    vec_t v;
    v.name = name; v.valid = valid; v.wr = wr;
    v.a1 = a1; v.a2 = a2; v.ad = ad; v.an = an;
    v.b1 = b1; v.b2 = b2; v.bd = bd; v.bn = bn;
    v.cv = cv; v.c0 = c0; v.c1 = c1;
    v.e_a1 = e_a1; v.r_a1 = r_a1; v.e_a2 = e_a2; v.r_a2 = r_a2;
    v.e_b1 = e_b1; v.r_b1 = r_b1; v.e_b2 = e_b2; v.r_b2 = r_b2;
    v.omask = omask; v.eo0 = eo0; v.eo1 = eo1;
    return v;
  endfunction

  // Driver tasks
  task automatic drive_idle();
    rollback = 1'b0; dp_valid = '0; dp_wr_en = '0;
    dp_rs1 = '0; dp_rs2 = '0; dp_rd = '0; dp_tag_new = '0;
    cdb_valid = '0; cdb_tag = '0;
  endtask

  task automatic lookup_s0(input logic [4:0] a1, input logic [4:0] a2);
    drive_idle();
    dp_rs1 = {5'd0, a1};
    dp_rs2 = {5'd0, a2};
  endtask

  // Inputs change on the falling edge; outputs are checked 1ns later and
  // the table updates on the following rising edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rollback   = 1'b0;
    dp_valid   = v.valid;
    dp_wr_en   = v.wr;
    dp_rs1     = {v.b1, v.a1};
    dp_rs2     = {v.b2, v.a2};
    dp_rd      = {v.bd, v.ad};
    dp_tag_new = {v.bn, v.an};
    cdb_valid  = v.cv;
    cdb_tag    = {v.c1, v.c0};
    #1;
    check({v.name, ".s0_rs1_tag"}, rs1_tag[0 +: T], v.e_a1);
    check({v.name, ".s0_rs1_rdy"}, T'(rs1_ready[0]), T'(v.r_a1));
    check({v.name, ".s0_rs2_tag"}, rs2_tag[0 +: T], v.e_a2);
    check({v.name, ".s0_rs2_rdy"}, T'(rs2_ready[0]), T'(v.r_a2));
    check({v.name, ".s1_rs1_tag"}, rs1_tag[T +: T], v.e_b1);
    check({v.name, ".s1_rs1_rdy"}, T'(rs1_ready[1]), T'(v.r_b1));
    check({v.name, ".s1_rs2_tag"}, rs2_tag[T +: T], v.e_b2);
    check({v.name, ".s1_rs2_rdy"}, T'(rs2_ready[1]), T'(v.r_b2));
    if (v.omask[0]) check({v.name, ".tag_old0"}, tag_old[0 +: T], v.eo0);
    if (v.omask[1]) check({v.name, ".tag_old1"}, tag_old[T +: T], v.eo1);
  endtask

  localparam int NV = 13;
  vec_t vecs[NV];

  initial begin
    // Directed vectors, applied back to back from reset state
    //            name              val    wr     a1 a2 ad an  b1 b2 bd bn  cv     c0 c1  e_a1 r   e_a2 r   e_b1 r   e_b2 r   om     o0 o1
    vecs[0]  = mk("reset",          2'b01, 2'b00, 5, 0, 0, 0,  1, 2, 0, 0,  2'b00,  0, 0,  5, 1,   0, 1,   1, 1,   2, 1,   2'b00, 0, 0);
    vecs[1]  = mk("rename_fwd",     2'b11, 2'b11, 4, 3, 3, 40, 3, 0, 3, 41, 2'b00,  0, 0,  4, 1,   3, 1,   40, 0,  0, 1,   2'b11, 3, 40);
    vecs[2]  = mk("after_fwd",      2'b00, 2'b00, 3, 7, 0, 0,  6, 3, 0, 0,  2'b00,  0, 0,  41, 0,  7, 1,   6, 1,   41, 0,  2'b00, 0, 0);
    vecs[3]  = mk("rename_x7",      2'b01, 2'b01, 7, 7, 7, 45, 0, 0, 0, 0,  2'b00,  0, 0,  7, 1,   7, 1,   0, 1,   0, 1,   2'b01, 7, 0);
    vecs[4]  = mk("cdb_bypass",     2'b00, 2'b00, 7, 3, 0, 0,  3, 7, 0, 0,  2'b01, 45, 0,  45, 1,  41, 0,  41, 0,  45, 1,  2'b00, 0, 0);
    vecs[5]  = mk("cdb_stored",     2'b00, 2'b00, 7, 3, 0, 0,  0, 0, 0, 0,  2'b00,  0, 0,  45, 1,  41, 0,  0, 1,   0, 1,   2'b00, 0, 0);
    vecs[6]  = mk("cdb_lane1",      2'b00, 2'b00, 3, 0, 0, 0,  0, 0, 0, 0,  2'b10,  0, 41, 41, 1,  0, 1,   0, 1,   0, 1,   2'b00, 0, 0);
    vecs[7]  = mk("cdb_vs_write",   2'b11, 2'b01, 7, 3, 7, 50, 7, 3, 0, 0,  2'b01, 45, 0,  45, 1,  41, 1,  50, 0,  41, 1,  2'b01, 45, 0);
    vecs[8]  = mk("write_won",      2'b00, 2'b00, 7, 3, 0, 0,  0, 0, 0, 0,  2'b00,  0, 0,  50, 0,  41, 1,  0, 1,   0, 1,   2'b00, 0, 0);
    vecs[9]  = mk("x0_write",       2'b11, 2'b11, 0, 7, 0, 60, 0, 5, 5, 61, 2'b00,  0, 0,  0, 1,   50, 0,  0, 1,   5, 1,   2'b10, 0, 5);
    vecs[10] = mk("same_rd",        2'b11, 2'b11, 0, 5, 9, 20, 5, 0, 9, 21, 2'b00,  0, 0,  0, 1,   61, 0,  61, 0,  0, 1,   2'b11, 9, 20);
    vecs[11] = mk("invalid_slot",   2'b00, 2'b01, 9, 9, 9, 33, 9, 5, 0, 0,  2'b00,  0, 0,  21, 0,  21, 0,  21, 0,  61, 0,  2'b00, 0, 0);
    vecs[12] = mk("cdb_nomatch",    2'b00, 2'b00, 9, 0, 0, 0,  1, 2, 0, 0,  2'b01, 22, 21, 21, 0,  0, 1,   1, 1,   2, 1,   2'b00, 0, 0);

    drive_idle();
    for (int i = 0; i < NE; i++) amt_tag[i*T +: T] = T'(i + 32);
    rst_n = 1'b0;

    // Reset state visible combinationally while reset is held
    @(negedge clk);
    lookup_s0(5'd5, 5'd0);
    #1;
    check("in_reset.rs1_tag", rs1_tag[0 +: T], 6'd5);
    check("in_reset.rs1_rdy", T'(rs1_ready[0]), 6'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(vecs[i]);

    // Rollback with a concurrent dispatch and CDB that must be ignored
    @(negedge clk);
    drive_idle();
    rollback   = 1'b1;
    dp_valid   = 2'b01;
    dp_wr_en   = 2'b01;
    dp_rd      = {5'd0, 5'd4};
    dp_tag_new = {6'd0, 6'd10};
    cdb_valid  = 2'b01;
    cdb_tag    = {6'd0, 6'd21};
    @(negedge clk);
    for (int i = 1; i < NE; i++) begin
      lookup_s0(5'(i), 5'(i));
      #1;
      check($sformatf("rollback.x%0d_tag", i), rs1_tag[0 +: T], T'(i + 32));
      check($sformatf("rollback.x%0d_rdy", i), T'(rs2_ready[0]), 6'd1);
    end
    lookup_s0(5'd0, 5'd4);
    #1;
    check("rollback.x0_tag", rs1_tag[0 +: T], 6'd0);
    check("rollback.x0_rdy", T'(rs1_ready[0]), 6'd1);
    check("rollback.x4_no_dispatch", rs2_tag[0 +: T], 6'd36);

    // Rename after rollback, then asynchronous reset mid-cycle with
    // rollback held high: reset must win and act immediately.
    @(negedge clk);
    drive_idle();
    dp_valid = 2'b01; dp_wr_en = 2'b01; dp_rd = {5'd0, 5'd5}; dp_tag_new = {6'd0, 6'd12};
    @(negedge clk);
    lookup_s0(5'd5, 5'd6);
    #1;
    check("pre_reset.x5_tag", rs1_tag[0 +: T], 6'd12);
    check("pre_reset.x5_rdy", T'(rs1_ready[0]), 6'd0);
    #2;
    rst_n    = 1'b0;
    rollback = 1'b1;
    #1;
    check("async_reset.x5_tag", rs1_tag[0 +: T], 6'd5);
    check("async_reset.x5_rdy", T'(rs1_ready[0]), 6'd1);
    check("async_reset.x6_tag", rs2_tag[0 +: T], 6'd6);
    @(negedge clk);
    #1;
    check("reset_over_rollback.x5", rs1_tag[0 +: T], 6'd5);
    rollback = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global timeout so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
